// File: rtl/rc4_prga_engine.sv
// RC4 keystream generator / decryptor (PRGA phase) with its own sequencer.
// Walks 9 cycles per byte over single-port, 1-cycle-latency S/enc/dec memories.
module rc4_prga_engine #(
  parameter int          ADDR_W   = 5,
  parameter bit          CHECK_EN = 1'b1,
  parameter logic [7:0]  LO_CHAR  = 8'h61,
  parameter logic [7:0]  HI_CHAR  = 8'h7A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   msg_len,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  input  logic [7:0]        s_rddata,
  output logic [ADDR_W-1:0] enc_addr,
  input  logic [7:0]        enc_rddata,
  output logic [ADDR_W-1:0] dec_addr,
  output logic [7:0]        dec_wrdata,
  output logic              dec_wren,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, RD_F, WT_F, WR_D, DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state, state_nx;
  logic [7:0]        i, j, si, sj, f, e;
  logic [ADDR_W:0]   k, len, count_r, len_sat, k_inc;
  logic              fail_r;
  logic [7:0]        dec_byte;
  logic              bad_byte;

  assign len_sat  = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
  assign k_inc    = k + ONE;
  assign dec_byte = f ^ e;
  // Space is always accepted as plaintext, everything else must be in range.
  assign bad_byte = CHECK_EN && (dec_byte != 8'h20) &&
                    ((dec_byte < LO_CHAR) || (dec_byte > HI_CHAR));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      si      <= '0;
      sj      <= '0;
      f       <= '0;
      e       <= '0;
      k       <= '0;
      len     <= '0;
      count_r <= '0;
      fail_r  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            i       <= '0;
            j       <= '0;
            k       <= '0;
            count_r <= '0;
            fail_r  <= 1'b0;
            len     <= len_sat;
          end
        end
        RD_I: i <= i + 8'd1;
        WT_I: begin
          si <= s_rddata;
          j  <= j + s_rddata;
        end
        WT_J: sj <= s_rddata;
        WT_F: begin
          f <= s_rddata;
          e <= enc_rddata;
        end
        WR_D: begin
          k       <= k_inc;
          count_r <= k_inc;
          if (bad_byte) fail_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // si and sj are both captured before either write, so i==j leaves S intact.
  always_comb begin
    state_nx   = state;
    s_addr     = '0;
    s_wrdata   = '0;
    s_wren     = 1'b0;
    enc_addr   = '0;
    dec_addr   = '0;
    dec_wrdata = '0;
    dec_wren   = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (len_sat == '0) ? DONE : RD_I;
      end
      RD_I: begin
        s_addr   = i + 8'd1;
        state_nx = WT_I;
      end
      WT_I: state_nx = RD_J;
      RD_J: begin
        s_addr   = j;
        state_nx = WT_J;
      end
      WT_J: state_nx = WR_I;
      WR_I: begin
        s_addr   = i;
        s_wrdata = sj;
        s_wren   = 1'b1;
        state_nx = WR_J;
      end
      WR_J: begin
        s_addr   = j;
        s_wrdata = si;
        s_wren   = 1'b1;
        state_nx = RD_F;
      end
      RD_F: begin
        s_addr   = si + sj;
        enc_addr = k[ADDR_W-1:0];
        state_nx = WT_F;
      end
      WT_F: state_nx = WR_D;
      WR_D: begin
        dec_addr   = k[ADDR_W-1:0];
        dec_wrdata = dec_byte;
        dec_wren   = 1'b1;
        if (bad_byte)         state_nx = DONE;
        else if (k_inc == len) state_nx = DONE;
        else                  state_nx = RD_I;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign fail  = fail_r;
  assign count = count_r;

endmodule
